// File: rtl/tlut_pkg.sv
// Shared types and default sizing for the temporal-LUT sequencer.
package tlut_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    OUT
  } tlut_ctrl_state_e;

  localparam int DIM_A_DEF        = 4;
  localparam int DIM_C_DEF        = 4;
  localparam int INPUT_WIDTH_DEF  = 8;
  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF    = 16;
  localparam int CELL_LAT_DEF     = 2;

  localparam int WIN     = 2 ** INPUT_WIDTH_DEF;
  localparam int DRAIN_W = $clog2(CELL_LAT_DEF + 1);

endpackage

// File: rtl/tlut_window_cnt.sv
// Up-counter from 0 to LAST; wrap pulses on the counting cycle that returns it to 0.
module tlut_window_cnt #(
  parameter int W    = 8,
  parameter int LAST = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         count_en,
  output logic         wrap,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  assign wrap = count_en && (cnt == LAST_V);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/tlut_seq_ctrl.sv
// Tile sequencer for one temporal-LUT SIMD cell: load operands, run one window,
// drain the cell pipeline, then hand the product vector downstream.
//
// state | meaning
// IDLE  | waiting for an operand tile (in_ready=1)
// LOAD  | cell samples operands, enable low
// RUN   | cell enable high for one full window
// DRAIN | enable low while the cell pipeline settles; capture on last cycle
// OUT   | result held under out_valid until out_ready
module tlut_seq_ctrl
  import tlut_pkg::*;
#(
  parameter int DIM_A        = DIM_A_DEF,
  parameter int DIM_C        = DIM_C_DEF,
  parameter int INPUT_WIDTH  = INPUT_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int CELL_LAT     = CELL_LAT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DIM_A*INPUT_WIDTH-1:0]    in_act,
  input  logic [DIM_C*WEIGHT_WIDTH-1:0]   in_wgt,
  output logic [DIM_A*INPUT_WIDTH-1:0]    cell_input_bin,
  output logic [DIM_C*WEIGHT_WIDTH-1:0]   cell_weight_bin,
  output logic                            cell_enable,
  input  logic [DIM_A*ACC_WIDTH-1:0]      cell_product,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DIM_A*ACC_WIDTH-1:0]      out_data,
  output logic                            busy
);

  localparam int WIN_CYC = 1 << INPUT_WIDTH;
  localparam int DW      = $clog2(CELL_LAT + 1);

  tlut_ctrl_state_e state;

  logic [DIM_A*INPUT_WIDTH-1:0]  act_q;
  logic [DIM_C*WEIGHT_WIDTH-1:0] wgt_q;
  logic                          win_wrap;
  logic                          drain_wrap;
  logic [INPUT_WIDTH-1:0]        win_cnt;
  logic [DW-1:0]                 drain_cnt;
  logic                          unused_cnt;

  tlut_window_cnt #(.W(INPUT_WIDTH), .LAST(WIN_CYC - 1)) u_win_cnt (
    .clk      (clk),
    .rst      (rst),
    .start    (state == LOAD),
    .count_en (state == RUN),
    .wrap     (win_wrap),
    .cnt      (win_cnt)
  );

  tlut_window_cnt #(.W(DW), .LAST(CELL_LAT - 1)) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .start    (state == RUN),
    .count_en (state == DRAIN),
    .wrap     (drain_wrap),
    .cnt      (drain_cnt)
  );

  // Sequencing runs off the wrap pulses; the count values are not needed here.
  assign unused_cnt = ^{win_cnt, drain_cnt};

  assign cell_input_bin  = act_q;
  assign cell_weight_bin = wgt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      cell_enable <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_data    <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            act_q    <= in_act;
            wgt_q    <= in_wgt;
            state    <= LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          state       <= RUN;
          cell_enable <= 1'b1;
        end
        RUN: begin
          if (win_wrap) begin
            state       <= DRAIN;
            cell_enable <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_wrap) begin
            out_data  <= cell_product;
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready    <= 1'b0;
          cell_enable <= 1'b0;
          out_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlut_seq_ctrl.sv
// Directed bench for tlut_seq_ctrl with a behavioural temporal-LUT cell (WIN=16, CELL_LAT=2).
module tb_tlut_seq_ctrl;

  localparam int DA = 4;
  localparam int DC = 4;
  localparam int IW = 4;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam int CL = 2;
  localparam int WINC = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DA*IW-1:0]  in_act;
  logic [DC*WW-1:0]  in_wgt;
  logic [DA*IW-1:0]  cell_input_bin;
  logic [DC*WW-1:0]  cell_weight_bin;
  logic              cell_enable;
  logic [DA*AW-1:0]  cell_product;
  logic              out_valid;
  logic              out_ready;
  logic [DA*AW-1:0]  out_data;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  tlut_seq_ctrl #(
    .DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(AW), .CELL_LAT(CL)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .cell_input_bin(cell_input_bin),
    .cell_weight_bin(cell_weight_bin), .cell_enable(cell_enable),
    .cell_product(cell_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cell: rollover counter, compare register, product register.
  logic [IW-1:0] mcnt;
  logic [DA-1:0] cmp;
  logic          en_d;
  logic          first_d;
  logic [DA*AW-1:0] prod;
  assign cell_product = prod;

  always @(posedge clk) begin
    if (rst) begin
      mcnt <= '0; cmp <= '0; en_d <= 1'b0; first_d <= 1'b0; prod <= '0;
    end else begin
      if (cell_enable) mcnt <= mcnt + 4'd1;
      en_d    <= cell_enable;
      first_d <= cell_enable && (mcnt == 4'd0);
      for (int a = 0; a < DA; a++) begin
        cmp[a] <= (mcnt < cell_input_bin[a*IW +: IW]);
        if (en_d)
          prod[a*AW +: AW] <= (first_d ? 16'd0 : prod[a*AW +: AW]) +
                              (cmp[a] ? {8'd0, cell_weight_bin[a*WW +: WW]} : 16'd0);
      end
    end
  end

  function automatic logic [DA*AW-1:0] exp_prod(input logic [DA*IW-1:0] act,
                                                input logic [DC*WW-1:0] wgt);
    logic [DA*AW-1:0] r;
    r = '0;
    for (int a = 0; a < DA; a++)
      r[a*AW +: AW] = 16'(act[a*IW +: IW]) * 16'(wgt[a*WW +: WW]);
    return r;
  endfunction

  // Returns at the negedge of the LOAD cycle; t_acc is the accepting cycle.
  task automatic accept_tile(input logic [DA*IW-1:0] act, input logic [DC*WW-1:0] wgt,
                             output int t_acc);
    in_act = act; in_wgt = wgt; in_valid = 1'b1; t_acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin t_acc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (t_acc < 0) begin $display("FAIL accept_timeout in_ready=%0b want 1", in_ready); bad++; end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [DA*AW-1:0] data);
    int k;
    k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    data = out_data;
    total++;
    if (!out_valid) begin $display("FAIL out_timeout out_valid=%0b want 1", out_valid); bad++; end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_act = 16'hABCD; in_wgt = 32'h11223344; out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got=%0b want 0", in_ready); bad++; end
    total++; if (cell_enable !== 1'b0) begin $display("FAIL rst_enable got=%0b want 0", cell_enable); bad++; end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_valid_busy got=%0b%0b want 00", out_valid, busy); bad++; end
    total++; if (out_data !== '0 || cell_input_bin !== '0 || cell_weight_bin !== '0) begin
      $display("FAIL rst_data got=%h/%h/%h want 0", out_data, cell_input_bin, cell_weight_bin); bad++; end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rst_no_accept busy=%0b in_ready=%0b want 0 1", busy, in_ready); bad++; end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t, en_cnt, first, last, ov_at;
    logic [DA*AW-1:0] data;
    en_cnt = 0; first = -1; last = -1; ov_at = -1; data = '0;
    out_ready = 1'b1;
    accept_tile({4'd8, 4'd15, 4'd0, 4'd3}, {8'd40, 8'd30, 8'd20, 8'd10}, t);
    for (int k = 1; k <= WINC + CL + 3; k++) begin
      if (cell_enable) begin en_cnt++; if (first < 0) first = k; last = k; end
      if (out_valid && ov_at < 0) begin ov_at = k; data = out_data; end
      if (k == WINC + CL + 3) begin
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
          $display("FAIL single_idle busy=%0b ov=%0b rdy=%0b want 0 0 1", busy, out_valid, in_ready); bad++; end
      end
      @(negedge clk);
    end
    total++; if (first != 2 || last != WINC + 1) begin
      $display("FAIL single_enable_span got=%0d..%0d want 2..17", first, last); bad++; end
    total++; if (en_cnt != WINC) begin $display("FAIL single_enable_count got=%0d want 16", en_cnt); bad++; end
    total++; if (ov_at != WINC + CL + 2) begin $display("FAIL single_out_valid_offset got=%0d want 20", ov_at); bad++; end
    total++; if (data !== {16'd320, 16'd450, 16'd0, 16'd30}) begin
      $display("FAIL single_data got=%h want %h", data, {16'd320, 16'd450, 16'd0, 16'd30}); bad++; end
  endtask

  task automatic test_backpressure();
    int t, unstable;
    logic [DA*AW-1:0] data;
    logic [DA*AW-1:0] want;
    want = {16'd3, 16'd10, 16'd63, 16'd44};
    unstable = 0;
    out_ready = 1'b0;
    accept_tile({4'd1, 4'd2, 4'd9, 4'd4}, {8'd3, 8'd5, 8'd7, 8'd11}, t);
    wait_out(data);
    total++; if (data !== want) begin $display("FAIL bp_data got=%h want %h", data, want); bad++; end
    in_act = 16'h5555; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b1 || out_data !== want || in_ready !== 1'b0 || busy !== 1'b1) unstable++;
      @(negedge clk);
    end
    total++; if (unstable != 0) begin $display("FAIL bp_hold bad_cycles=%0d want 0", unstable); bad++; end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release busy=%0b rdy=%0b ov=%0b want 0 1 0", busy, in_ready, out_valid); bad++; end
    @(negedge clk);
    total++; if (busy !== 1'b1 || cell_input_bin !== 16'h5555) begin
      $display("FAIL bp_pending_accept busy=%0b act=%h want 1 5555", busy, cell_input_bin); bad++; end
    in_valid = 1'b0;
    wait_out(data);
    total++; if (data !== exp_prod(16'h5555, {8'd3, 8'd5, 8'd7, 8'd11})) begin
      $display("FAIL bp_second_data got=%h want %h", data, exp_prod(16'h5555, {8'd3, 8'd5, 8'd7, 8'd11})); bad++; end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DA*IW-1:0] tiles [5];
    int acc_cyc [5];
    int n_acc, n_out;
    logic prev_en;
    logic [DC*WW-1:0] w;
    tiles[0] = 16'h1234; tiles[1] = 16'hABCD; tiles[2] = 16'h0F0F;
    tiles[3] = 16'h7777; tiles[4] = 16'hFFFF;
    w = 32'h04030201;
    in_wgt = w; out_ready = 1'b1; n_acc = 0; n_out = 0; prev_en = 1'b0;
    for (int i = 0; i < 5; i++) acc_cyc[i] = 0;
    for (int c = 0; c < 200 && n_out < 5; c++) begin
      in_valid = (n_acc < 5);
      if (n_acc < 5) in_act = tiles[n_acc];
      if (in_valid && in_ready) begin acc_cyc[n_acc] = cyc; n_acc++; end
      if (cell_enable && !prev_en) begin
        total++; if (mcnt !== 4'd0) begin $display("FAIL b2b_cell_cnt got=%0d want 0", mcnt); bad++; end
      end
      prev_en = cell_enable;
      if (out_valid) begin
        total++; if (out_data !== exp_prod(tiles[n_out], w)) begin
          $display("FAIL b2b_data idx=%0d got=%h want %h", n_out, out_data, exp_prod(tiles[n_out], w)); bad++; end
        n_out++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (n_out != 5 || n_acc != 5) begin $display("FAIL b2b_count got=%0d/%0d want 5/5", n_acc, n_out); bad++; end
    for (int i = 1; i < 5; i++) begin
      total++; if (acc_cyc[i] - acc_cyc[i-1] != WINC + CL + 3) begin
        $display("FAIL b2b_period idx=%0d got=%0d want 21", i, acc_cyc[i] - acc_cyc[i-1]); bad++; end
    end
  endtask

  task automatic test_reset_mid_run();
    int t, k;
    logic [DA*AW-1:0] data;
    out_ready = 1'b1;
    accept_tile(16'hCCCC, 32'h09090909, t);
    k = 0;
    while (!(cell_enable && mcnt == 4'd7) && k < 40) begin @(negedge clk); k++; end
    total++; if (!(cell_enable && mcnt == 4'd7)) begin $display("FAIL midrst_reach cnt=%0d want 7", mcnt); bad++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || cell_enable !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL midrst_state busy=%0b en=%0b ov=%0b want 0 0 0", busy, cell_enable, out_valid); bad++; end
    accept_tile({4'd2, 4'd5, 4'd11, 4'd6}, {8'd9, 8'd17, 8'd33, 8'd100}, t);
    wait_out(data);
    total++; if (data !== {16'd18, 16'd85, 16'd363, 16'd600}) begin
      $display("FAIL midrst_data got=%h want %h", data, {16'd18, 16'd85, 16'd363, 16'd600}); bad++; end
    @(negedge clk);
  endtask

  task automatic test_operand_stability();
    int t, unstable, n;
    logic [DA*AW-1:0] data;
    out_ready = 1'b1; unstable = 0; n = 0; data = '0;
    accept_tile(16'h9E3A, 32'hF00DCAFE, t);
    for (int k = 0; k < 40; k++) begin
      in_act = 16'($urandom);
      if (cell_input_bin !== 16'h9E3A || cell_weight_bin !== 32'hF00DCAFE) unstable++;
      n++;
      if (out_valid) data = out_data;
      if (!busy) break;
      @(negedge clk);
    end
    total++; if (unstable != 0 || n < WINC + CL + 2) begin
      $display("FAIL stab_operands bad=%0d cycles=%0d want 0 and >=20", unstable, n); bad++; end
    total++; if (data !== exp_prod(16'h9E3A, 32'hF00DCAFE)) begin
      $display("FAIL stab_data got=%h want %h", data, exp_prod(16'h9E3A, 32'hF00DCAFE)); bad++; end
    @(negedge clk);
  endtask

  task automatic test_edges();
    int t;
    logic [DA*AW-1:0] data;
    out_ready = 1'b1;
    accept_tile(16'h0000, {8'd255, 8'd128, 8'd7, 8'd1}, t);
    wait_out(data);
    total++; if (data !== '0) begin $display("FAIL edge_zero got=%h want 0", data); bad++; end
    @(negedge clk);
    accept_tile(16'hFFFF, {8'd255, 8'd128, 8'd7, 8'd1}, t);
    wait_out(data);
    total++; if (data !== {16'd3825, 16'd1920, 16'd105, 16'd15}) begin
      $display("FAIL edge_full got=%h want %h", data, {16'd3825, 16'd1920, 16'd105, 16'd15}); bad++; end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_operand_stability();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
